// File: rtl/det_seq_pkg.sv
// det_seq_pkg: size encodings, FSM states and cofactor term tables for det_seq_ctrl
package det_seq_pkg;
  localparam int ELEM_W = 8;
  localparam int ROW_STRIDE = 40;
  localparam logic [1:0] SZ_1X1 = 2'b00;
  localparam logic [1:0] SZ_2X2 = 2'b01;
  localparam logic [1:0] SZ_3X3 = 2'b10;
  typedef enum logic [1:0] {IDLE, MUL_A, MUL_B, FINISH} state_e;
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
    logic       neg;
  } term_t;
  function automatic logic [7:0] elem(input int r, input int c);
    return 8'(r * ROW_STRIDE + c * ELEM_W);
  endfunction
  // x,y,z are bit offsets into the flattened matrix; neg subtracts the term
  localparam term_t T3 [6] = '{
    '{elem(0, 0), elem(1, 1), elem(2, 2), 1'b0},
    '{elem(0, 1), elem(1, 2), elem(2, 0), 1'b0},
    '{elem(0, 2), elem(1, 0), elem(2, 1), 1'b0},
    '{elem(0, 2), elem(1, 1), elem(2, 0), 1'b1},
    '{elem(0, 1), elem(1, 0), elem(2, 2), 1'b1},
    '{elem(0, 0), elem(1, 2), elem(2, 1), 1'b1}
  };
  localparam term_t T2 [2] = '{
    '{elem(0, 0), elem(1, 1), 8'd0, 1'b0},
    '{elem(0, 1), elem(1, 0), 8'd0, 1'b1}
  };
endpackage

// File: rtl/det_seq_ctrl_mul.sv
// det_mul_16x8: combinational signed 16x8 -> 24 multiplier shared by both multiply steps
module det_mul_16x8 (
  input  logic signed [15:0] a_i,
  input  logic signed [7:0]  b_i,
  output logic signed [23:0] p_o
);
  assign p_o = 24'(a_i) * 24'(b_i);
endmodule

// File: rtl/det_seq_ctrl.sv
// det_seq_ctrl: multi-cycle 1x1/2x2/3x3 determinant sequencer with one shared multiplier
module det_seq_ctrl
  import det_seq_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int ELEM_W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   size,
  input  logic [199:0] A_flat,
  output logic         busy,
  output logic         done,
  output logic [7:0]   det,
  output logic         overflow_flag,
  output logic         error
);
  state_e state_q, state_d;
  logic [199:0] a_q, a_d;
  logic [1:0] size_q, size_d;
  logic [2:0] term_q, term_d;
  logic signed [15:0] part_q, part_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, fin;
  logic busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, err_q, err_d;
  logic [7:0] det_q, det_d;
  term_t t;
  logic signed [ELEM_W-1:0] x, y, z;
  logic signed [15:0] m_a;
  logic signed [7:0] m_b;
  logic signed [23:0] prod;
  logic is3, last, second;
  assign is3 = size_q == SZ_3X3;
  assign t = is3 ? T3[term_q] : T2[term_q[0]];
  assign x = a_q[t.x +: ELEM_W];
  assign y = a_q[t.y +: ELEM_W];
  assign z = a_q[t.z +: ELEM_W];
  // 3x3 MUL_B multiplies the stored partial by z; every other step multiplies x by y
  assign second = state_q == MUL_B && is3;
  assign m_a = second ? part_q : 16'(x);
  assign m_b = second ? z : y;
  assign last = is3 ? term_q == 3'd5 : term_q[0];
  // 1x1 selects T2[0].x, which is element (0,0)
  assign fin = size_q == SZ_1X1 ? ACC_W'(x) : (is3 || size_q == SZ_2X2) ? acc_q : '0;
  det_mul_16x8 u_mul (.a_i(m_a), .b_i(m_b), .p_o(prod));
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      size_q  <= '0;
      term_q  <= '0;
      part_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      det_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      size_q  <= size_d;
      term_q  <= term_d;
      part_q  <= part_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      det_q   <= det_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    term_d  = term_q;
    case (state_q)
      IDLE: if (start) begin
        term_d  = '0;
        state_d = size == SZ_3X3 ? MUL_A : size == SZ_2X2 ? MUL_B : FINISH;
      end
      MUL_A: state_d = MUL_B;
      MUL_B: begin
        term_d  = last ? term_q : term_q + 3'd1;
        state_d = last ? FINISH : is3 ? MUL_A : MUL_B;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    a_d    = a_q;
    size_d = size_q;
    part_d = part_q;
    acc_d  = acc_q;
    busy_d = busy_q;
    done_d = 1'b0;
    det_d  = det_q;
    ovf_d  = ovf_q;
    err_d  = err_q;
    case (state_q)
      IDLE: if (start) begin
        a_d    = A_flat;
        size_d = size;
        acc_d  = '0;
        busy_d = 1'b1;
      end
      MUL_A: part_d = prod[15:0];
      MUL_B: acc_d = t.neg ? acc_q - ACC_W'(prod) : acc_q + ACC_W'(prod);
      default: begin
        acc_d  = fin;
        det_d  = fin[7:0];
        ovf_d  = fin > ACC_W'(127) || fin < -ACC_W'(128);
        err_d  = size_q == 2'b11;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end
  assign busy = busy_q;
  assign done = done_q;
  assign det = det_q;
  assign overflow_flag = ovf_q;
  assign error = err_q;
endmodule

// File: tb/tb_det_seq_ctrl.sv
// tb_det_seq_ctrl: scoreboard bench for det_seq_ctrl with an independent cofactor-expansion model
module tb_det_seq_ctrl;
  typedef struct {
    logic [7:0] det;
    logic       ovf;
    logic       err;
    int         lat;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [1:0] size = 2'b00;
  logic [199:0] A_flat = '0;
  logic busy, done, overflow_flag, error;
  logic [7:0] det;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];
  det_seq_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .size(size), .A_flat(A_flat),
    .busy(busy), .done(done), .det(det), .overflow_flag(overflow_flag), .error(error)
  );
  always #5 clock = ~clock;
  function automatic int el(input logic [199:0] a, input int r, input int c);
    logic signed [7:0] v;
    v = a[40*r+8*c +: 8];
    return int'(v);
  endfunction
  function automatic exp_t model(input logic [1:0] sz, input logic [199:0] a);
    exp_t e;
    int d;
    case (sz)
      2'b00: d = el(a, 0, 0);
      2'b01: d = el(a, 0, 0) * el(a, 1, 1) - el(a, 0, 1) * el(a, 1, 0);
      2'b10: d = el(a, 0, 0) * (el(a, 1, 1) * el(a, 2, 2) - el(a, 1, 2) * el(a, 2, 1))
               - el(a, 0, 1) * (el(a, 1, 0) * el(a, 2, 2) - el(a, 1, 2) * el(a, 2, 0))
               + el(a, 0, 2) * (el(a, 1, 0) * el(a, 2, 1) - el(a, 1, 1) * el(a, 2, 0));
      default: d = 0;
    endcase
    e.det = d[7:0];
    e.ovf = d > 127 || d < -128;
    e.err = sz == 2'b11;
    e.lat = sz == 2'b10 ? 13 : sz == 2'b01 ? 3 : 1;
    return e;
  endfunction
  function automatic logic [199:0] mk(input int n, input int v[9]);
    logic [199:0] a;
    for (int i = 0; i < 25; i++) a[8*i +: 8] = 8'($urandom);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) a[40*r+8*c +: 8] = 8'(v[3*r+c]);
    return a;
  endfunction
  task automatic issue(input logic [1:0] sz, input logic [199:0] a);
    size = sz;
    A_flat = a;
    start = 1'b1;
    sb.push_back(model(sz, a));
  endtask
  // Call with start set up; returns #1 after the done edge. hold keeps start high and scrambles inputs.
  task automatic wait_done(input string name, input bit hold);
    exp_t e;
    int n, bc;
    @(posedge clock); #1;
    if (!hold) start = 1'b0;
    n = 0;
    bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      if (hold) begin
        A_flat = mk(0, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
        size = 2'($urandom);
      end
      @(posedge clock); #1;
      n++;
    end
    e = sb.pop_front();
    n_cmp++; if (n !== e.lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", name, n, e.lat); end
    n_cmp++; if (det !== e.det) begin n_bad++; $display("FAIL %s det: got %h want %h", name, det, e.det); end
    n_cmp++; if (overflow_flag !== e.ovf) begin n_bad++; $display("FAIL %s ovf: got %b want %b", name, overflow_flag, e.ovf); end
    n_cmp++; if (error !== e.err) begin n_bad++; $display("FAIL %s err: got %b want %b", name, error, e.err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
    n_cmp++; if (bc !== e.lat) begin n_bad++; $display("FAIL %s busy_cycles: got %0d want %0d", name, bc, e.lat); end
  endtask
  task automatic check_idle(input string name);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy: got %b want 0", name, busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s done: got %b want 0", name, done); end
    n_cmp++; if (det !== 8'h00) begin n_bad++; $display("FAIL %s det: got %h want 00", name, det); end
    n_cmp++; if (overflow_flag !== 1'b0) begin n_bad++; $display("FAIL %s ovf: got %b want 0", name, overflow_flag); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL %s err: got %b want 0", name, error); end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check_idle("reset");
    @(posedge clock); #1;
    check_idle("post_reset");
  endtask
  task automatic test_3x3();
    issue(2'b10, mk(3, '{2, -1, 0, 1, 3, 2, 0, 1, 4}));
    wait_done("m3_24", 0);
    issue(2'b10, mk(3, '{3, 0, 0, 0, 3, 0, 0, 0, 15}));
    wait_done("m3_diag135", 0);
    issue(2'b10, mk(3, '{-128, 0, 0, 0, -128, 0, 0, 0, -128}));
    wait_done("m3_min", 0);
    issue(2'b10, mk(3, '{1, 0, 0, 0, 1, 0, 0, 0, 1}));
    wait_done("m3_ident", 0);
    for (int i = 0; i < 4; i++) begin
      issue(2'b10, mk(0, '{0, 0, 0, 0, 0, 0, 0, 0, 0}));
      wait_done("m3_rand", 0);
    end
  endtask
  task automatic test_2x2_1x1();
    issue(2'b01, mk(2, '{7, 3, 0, 2, -4, 0, 0, 0, 0}));
    wait_done("m2_fixed", 0);
    issue(2'b00, mk(1, '{-5, 0, 0, 0, 0, 0, 0, 0, 0}));
    wait_done("m1_fixed", 0);
    for (int i = 0; i < 4; i++) begin
      issue(2'(i % 2), mk(0, '{0, 0, 0, 0, 0, 0, 0, 0, 0}));
      wait_done("m12_rand", 0);
    end
  endtask
  task automatic test_invalid();
    issue(2'b11, mk(3, '{9, 9, 9, 9, 9, 9, 9, 9, 9}));
    wait_done("invalid", 0);
    issue(2'b00, mk(1, '{42, 0, 0, 0, 0, 0, 0, 0, 0}));
    wait_done("after_invalid", 0);
  endtask
  task automatic test_back_to_back();
    issue(2'b10, mk(3, '{5, -2, 7, 1, 0, -3, 4, 6, 2}));
    wait_done("hold_3x3", 1);
    issue(2'b01, mk(2, '{-9, 4, 0, 11, 6, 0, 0, 0, 0}));
    wait_done("b2b_2x2", 0);
  endtask
  task automatic test_reset_mid();
    int cnt;
    issue(2'b10, mk(3, '{3, 0, 0, 0, 3, 0, 0, 0, 15}));
    wait_done("pre_abort", 0);
    size = 2'b10;
    A_flat = mk(3, '{2, -1, 0, 1, 3, 2, 0, 1, 4});
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    check_idle("abort");
    cnt = 0;
    repeat (16) begin
      @(posedge clock); #1;
      if (done) cnt++;
    end
    n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", cnt); end
    issue(2'b10, mk(3, '{1, 2, 3, 0, 1, 4, 5, 6, 0}));
    wait_done("after_abort", 0);
  endtask
  initial begin
    test_reset();
    test_3x3();
    test_2x2_1x1();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
